// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin arbiter in front of a single APB
// master. Each accepted request runs one SETUP + ACCESS sequence on the bus
// and returns a one-cycle completion pulse to the requester that owned it.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that wait
// longer than TIMEOUT_CYCLES for pready (the abort reports rsp_err=1).
module apb_master_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    prio_q;     // requester that wins when both ask
  logic                    grant_q;    // owner of the transfer in flight
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic                    accept_d;
  logic                    grant_d;
  logic [1:0]              req_ready_d;
  logic                    sel_write_d;
  logic [ADDR_WIDTH-1:0]   sel_addr_d;
  logic [DATA_WIDTH-1:0]   sel_wdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]        tmo_cnt_q;
`endif

  // Round-robin pick in IDLE; the accept strobe is combinational so the
  // requester sees it in the same cycle its request is captured.
  always_comb begin
    accept_d    = 1'b0;
    grant_d     = 1'b0;
    req_ready_d = 2'b00;
    if ((state_q == ST_IDLE) && !preset) begin
      case (req_valid)
        2'b01: begin
          accept_d = 1'b1;
          grant_d  = 1'b0;
        end
        2'b10: begin
          accept_d = 1'b1;
          grant_d  = 1'b1;
        end
        2'b11: begin
          accept_d = 1'b1;
          grant_d  = prio_q;
        end
        default: begin
          accept_d = 1'b0;
          grant_d  = 1'b0;
        end
      endcase
      if (accept_d) begin
        req_ready_d = grant_d ? 2'b10 : 2'b01;
      end else begin
        req_ready_d = 2'b00;
      end
    end else begin
      req_ready_d = 2'b00;
    end
  end

  // Select the granted requester's command fields.
  always_comb begin
    if (grant_d) begin
      sel_write_d = req_write[1];
      sel_addr_d  = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_wdata_d = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      sel_write_d = req_write[0];
      sel_addr_d  = req_addr[ADDR_WIDTH-1:0];
      sel_wdata_d = req_wdata[DATA_WIDTH-1:0];
    end
  end

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      grant_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= {TMO_W{1'b0}};
`endif
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            grant_q   <= grant_d;
            prio_q    <= ~grant_d;
            pwrite_q  <= sel_write_d;
            paddr_q   <= sel_addr_d;
            pwdata_q  <= sel_wdata_d;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end else begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          psel_q    <= 1'b1;
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= {TMO_W{1'b0}};
`endif
        end
        ST_ACCESS: begin
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            rsp_rdata_q <= pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
            rsp_err_q   <= pslverr;
            state_q     <= ST_IDLE;
`ifdef APB_TIMEOUT_EN
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Slave never answered: give up and report an error.
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b1;
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= {TMO_W{1'b0}};
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + TMO_W'(1);
`else
          end else begin
            psel_q      <= 1'b1;
            penable_q   <= 1'b1;
`endif
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: stimulus pushes expected accepts,
// bus phases and responses into queues; a monitor pops and compares them
// whenever the DUT shows req_ready, a SETUP phase or rsp_valid.
// The timeout case runs only when APB_TIMEOUT_EN is defined.
module tb_apb_master_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            preset;
  logic [1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;

  apb_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
  } apb_t;
  typedef struct {
    logic [1:0]    vld;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } rsp_t;

  logic [1:0] q_acc[$];
  apb_t       q_apb[$];
  rsp_t       q_rsp[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // slave behaviour for the next transfer
  int            cfg_waits = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic          cfg_err   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // APB slave: answers after cfg_waits wait states; drives junk outside ACCESS.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        pready  = (acc_cnt >= cfg_waits);
        prdata  = cfg_rdata;
        pslverr = cfg_err;
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: compares every DUT output event against the queues.
  initial begin
    logic prev_psel;
    int   acc_seen, acc_cyc;
    apb_t cur;
    rsp_t r;
    prev_psel = 1'b0; acc_seen = 0; acc_cyc = 0;
    cur.addr = '0; cur.write = 1'b0; cur.wdata = '0;
    forever begin
      @(negedge pclk);
      cyc++;
      if (rsp_valid != 2'b00) begin
        if (q_rsp.size() == 0) chk("unexpected_rsp_valid", rsp_valid, 2'b00);
        else begin
          r = q_rsp.pop_front();
          chk("rsp_valid", rsp_valid, r.vld);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_latency", cyc - acc_cyc, r.lat);
          chk("access_cycles", acc_seen, r.acc);
        end
      end
      if (req_ready != 2'b00) begin
        if (q_acc.size() == 0) chk("unexpected_req_ready", req_ready, 2'b00);
        else chk("req_ready", req_ready, q_acc.pop_front());
        acc_cyc = cyc;
      end
      if (penable) chk("penable_without_psel", psel, 1'b1);
      if (psel && !penable) begin
        chk("idle_gap_before_setup", prev_psel, 1'b0);
        if (q_apb.size() == 0) chk("unexpected_setup", psel, 1'b0);
        else begin
          cur = q_apb.pop_front();
          chk("setup_paddr", paddr, cur.addr);
          chk("setup_pwrite", pwrite, cur.write);
          chk("setup_pwdata", pwdata, cur.wdata);
        end
        acc_seen = 0;
      end
      if (psel && penable) begin
        acc_seen++;
        chk("access_hold", {paddr, pwrite}, {cur.addr, cur.write});
      end
      prev_psel = psel;
    end
  end

  // Issue one request from requester r and wait until it is accepted.
  task automatic issue(input int r, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int waits,
                       input logic [DW-1:0] s_rdata, input logic s_err,
                       input logic [DW-1:0] e_rdata, input logic e_err,
                       input int e_lat, input int e_acc);
    apb_t a;
    rsp_t q;
    bit   got;
    a.addr = addr; a.write = wr; a.wdata = wdata;
    q.vld = (r == 1) ? 2'b10 : 2'b01;
    q.rdata = e_rdata; q.err = e_err; q.lat = e_lat; q.acc = e_acc;
    q_acc.push_back(q.vld);
    q_apb.push_back(a);
    q_rsp.push_back(q);
    cfg_waits = waits; cfg_rdata = s_rdata; cfg_err = s_err;
    @(posedge pclk); #1;
    req_valid = q.vld;
    req_write[r] = wr;
    req_addr[r*AW +: AW] = addr;
    req_wdata[r*DW +: DW] = wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk);
      if (req_ready != 2'b00) got = 1'b1;
    end
    if (!got) chk("accept_timeout", got, 1'b1);
    @(posedge pclk); #1;
    // changes after accept must not reach the bus
    req_valid = 2'b00;
    req_write = ~req_write;
    req_addr  = {2{32'hFFFF_FFF0}};
    req_wdata = {2{32'h0F0F_0F0F}};
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge pclk);
      if (q_rsp.size() == 0) done = 1'b1;
    end
    if (!done) chk("rsp_timeout", q_rsp.size(), 0);
    @(posedge pclk); #1;
  endtask

  initial begin
    bit seen;
    int n;
    preset = 1'b1; req_valid = 2'b11; req_write = 2'b11;
    req_addr = {2{32'h1234_5678}}; req_wdata = {2{32'h8765_4321}};
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("reset_psel", psel, 1'b0);
    chk("reset_penable", penable, 1'b0);
    chk("reset_pwrite", pwrite, 1'b0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_req_ready", req_ready, 2'b00);
    @(posedge pclk); #1;
    preset = 1'b0; req_valid = 2'b00;

    // requester 0 write, no wait states: response 3 cycles after accept
    issue(0, 1'b1, 32'h10, 32'hA5, 0, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 3, 1);
    wait_done();
    // requester 1 read with 2 wait states
    issue(1, 1'b0, 32'h20, 32'h0, 2, 32'hDEAD, 1'b0, 32'hDEAD, 1'b0, 5, 3);
    wait_done();
    // slave error on requester 0 read
    issue(0, 1'b0, 32'h30, 32'h0, 0, 32'hBEEF, 1'b1, 32'hBEEF, 1'b1, 3, 1);
    wait_done();
    // requester 1 write, 1 wait state, error must not persist
    issue(1, 1'b1, 32'h34, 32'hC3C3, 1, 32'h7777, 1'b0, 32'h0, 1'b0, 4, 2);
    wait_done();

    // reset during ACCESS aborts without a response
    issue(0, 1'b0, 32'h40, 32'h0, 5, 32'h99, 1'b0, 32'h99, 1'b0, 8, 6);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge pclk);
      if (penable) seen = 1'b1;
    end
    chk("reach_access", seen, 1'b1);
    @(posedge pclk); #1;
    preset = 1'b1; req_valid = 2'b01;
    q_rsp.delete();
    @(posedge pclk);
    @(negedge pclk);
    chk("abort_psel", psel, 1'b0);
    chk("abort_penable", penable, 1'b0);
    chk("abort_paddr", paddr, 32'h0);
    chk("abort_req_ready", req_ready, 2'b00);
    @(posedge pclk); #1;
    preset = 1'b0; req_valid = 2'b00;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rsp_valid != 2'b00 || psel) n++;
    end
    chk("abort_quiet", n, 0);
    @(posedge pclk); #1;

    // both requesting for 4 transfers: grants 0,1,0,1
    cfg_waits = 0; cfg_rdata = 32'h77; cfg_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apb_t a;
      rsp_t q;
      a.addr  = (k % 2 == 0) ? 32'h100 : 32'h200;
      a.write = (k % 2 == 1);
      a.wdata = (k % 2 == 0) ? 32'h11 : 32'h22;
      q.vld   = (k % 2 == 0) ? 2'b01 : 2'b10;
      q.rdata = (k % 2 == 0) ? 32'h77 : 32'h0;
      q.err = 1'b0; q.lat = 3; q.acc = 1;
      q_acc.push_back(q.vld);
      q_apb.push_back(a);
      q_rsp.push_back(q);
    end
    req_write = 2'b10;
    req_addr  = {32'h200, 32'h100};
    req_wdata = {32'h22, 32'h11};
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge pclk);
      if (req_ready != 2'b00) n++;
    end
    chk("rr_accept_count", n, 4);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    wait_done();

`ifdef APB_TIMEOUT_EN
    // slave never ready: abort after 16 ACCESS cycles
    issue(1, 1'b0, 32'h50, 32'h0, 1000, 32'h1234, 1'b0, 32'h0, 1'b1, 18, 16);
    wait_done();
    @(negedge pclk);
    chk("timeout_idle_psel", psel, 1'b0);
    @(posedge pclk); #1;
`endif

    repeat (4) @(posedge pclk);
    chk("leftover_expectations", q_acc.size() + q_apb.size() + q_rsp.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before abort; used only when APB_TIMEOUT_EN is defined.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named per the codebase (`pclk`, `preset`), as listed below.
REQ-005 SHALL have port pclk  input  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port preset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  2  per-requester transfer request; bit i is requester i.
REQ-008 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-009 SHALL have port req_write  input  2  per-requester direction: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  2*ADDR_WIDTH  per-requester address; slice i is requester i.
REQ-011 SHALL have port req_wdata  input  2*DATA_WIDTH  per-requester write data.
REQ-012 SHALL have port rsp_valid  output  2  one-cycle completion pulse per requester.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, valid while any rsp_valid bit is high.
REQ-014 SHALL have port rsp_err  output  1  error flag, valid while any rsp_valid bit is high.
REQ-015 SHALL have ports psel, penable, pwrite  output  1 each  APB master controls.
REQ-016 SHALL have port paddr  output  ADDR_WIDTH  APB address.
REQ-017 SHALL have port pwdata  output  DATA_WIDTH  APB write data.
REQ-018 SHALL have ports prdata (input, DATA_WIDTH), pready (input, 1) and pslverr (input, 1): slave response.

Function
REQ-019 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-020 SHALL, in IDLE with any req_valid high, grant one requester, assert req_ready[grant] combinationally that cycle, register its write/addr/wdata, and go to SETUP.
REQ-021 SHALL arbitrate round-robin: with both requesting, grant the requester not granted last; with one requesting, grant it.
REQ-022 SHALL keep req_ready low outside IDLE; at most one bit SHALL be high in any cycle.
REQ-023 SHALL, in SETUP, drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-024 SHALL, in ACCESS, drive psel=1 and penable=1, holding paddr, pwrite and pwdata stable until pready is sampled high.
REQ-025 SHALL, on the pready=1 cycle, register prdata (0 for writes) and pslverr, pulse rsp_valid[grant] on the next cycle, and go to IDLE.
REQ-026 SHALL keep IDLE for at least one cycle with psel=0 and penable=0 after every transfer; there are no back-to-back SETUPs.
REQ-027 SHALL give a minimum accept-to-response latency of 3 cycles (accept in IDLE, SETUP, ACCESS with pready=1, rsp_valid on the next cycle); each wait state adds 1 cycle.
REQ-028 SHALL ignore changes to req_valid or req_* in SETUP and ACCESS; a request pending there waits for the next IDLE.
REQ-029 SHALL ignore pready and pslverr outside ACCESS.
REQ-030 SHALL hold paddr, pwdata and pwrite at their last values in IDLE.

Reset
REQ-031 SHALL, on preset=1 at a clock edge, go to IDLE with psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, round-robin priority on requester 0, and the timeout counter at 0.
REQ-032 SHALL abort a transfer in progress when preset is asserted, with no rsp_valid for it; req_ready SHALL be 0 while preset=1.

Configuration
REQ-033 SHALL, with APB_TIMEOUT_EN defined, count ACCESS cycles; if pready is still low after TIMEOUT_CYCLES cycles, it SHALL drop psel/penable, go to IDLE and respond with rsp_err=1 and rsp_rdata=0.
REQ-034 SHALL, with APB_TIMEOUT_EN undefined, wait in ACCESS indefinitely for pready, with no counter logic.

Verification
REQ-035 SHALL cover: req_valid=01, write, addr 0x10, wdata 0xA5, pready=1 in ACCESS -> SETUP, ACCESS, then rsp_valid=01 and rsp_err=0 on cycle 3.
REQ-036 SHALL cover: requester 1 read, addr 0x20, 2 wait states, prdata 0xDEAD -> penable high for 3 cycles, rsp_valid=10, rsp_rdata=0xDEAD.
REQ-037 SHALL cover: req_valid=11 held for 4 transfers after reset -> grant order 0,1,0,1, with psel low for at least 1 cycle between transfers.
REQ-038 SHALL cover: pslverr=1 with pready=1 -> rsp_err=1 for the granted requester only.
REQ-039 SHALL cover: preset pulsed during ACCESS -> psel=penable=0 the next cycle and no rsp_valid.
REQ-040 SHALL cover: with APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held at 0 -> rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles, and the FSM back in IDLE.
